// File: rtl/video_raster_gen.sv
// Character-cell raster timing generator: VRAM address, scan row, display enable, syncs, frame strobe.
// Optional blinking cursor qualifier when VIDEO_RASTER_CURSOR_EN is defined.
module video_raster_gen #(
  parameter int ADDR_WIDTH   = 11,
  parameter int START_ADDR   = 0,
  parameter int H_TOTAL      = 64,
  parameter int H_DISPLAYED  = 40,
  parameter int H_SYNC_POS   = 50,
  parameter int H_SYNC_WIDTH = 4,
  parameter int CHAR_HEIGHT  = 8,
  parameter int V_TOTAL_ROWS = 32,
  parameter int V_DISPLAYED  = 25,
  parameter int V_SYNC_ROW   = 28,
  parameter int V_SYNC_WIDTH = 4,
  parameter int V_ADJUST     = 6
`ifdef VIDEO_RASTER_CURSOR_EN
  ,
  parameter int CURSOR_START = 6,
  parameter int CURSOR_END   = 7,
  parameter int BLINK_FRAMES = 16
`endif
) (
  input  logic                  clk16_i,
  input  logic                  reset_i,
  input  logic                  cclk_en_i,
  input  logic                  col80_i,
  input  logic [ADDR_WIDTH-1:0] cursor_addr_i,
  output logic [ADDR_WIDTH-1:0] ma_o,
  output logic [3:0]            ra_o,
  output logic                  de_o,
  output logic                  h_sync_o,
  output logic                  v_sync_o,
  output logic                  frame_o,
  output logic                  cursor_o
);

  localparam int HW = $clog2(2 * H_TOTAL) + 1;
  localparam int RW = $clog2(V_TOTAL_ROWS + 1);
  localparam int VW = $clog2(V_SYNC_WIDTH + 1);

  localparam logic [HW-1:0] HT_40  = HW'(H_TOTAL);
  localparam logic [HW-1:0] HT_80  = HW'(2 * H_TOTAL);
  localparam logic [HW-1:0] HD_40  = HW'(H_DISPLAYED);
  localparam logic [HW-1:0] HD_80  = HW'(2 * H_DISPLAYED);
  localparam logic [HW-1:0] HSP_40 = HW'(H_SYNC_POS);
  localparam logic [HW-1:0] HSP_80 = HW'(2 * H_SYNC_POS);
  localparam logic [HW-1:0] HSW_40 = HW'(H_SYNC_WIDTH);
  localparam logic [HW-1:0] HSW_80 = HW'(2 * H_SYNC_WIDTH);

  localparam logic [RW-1:0]         ROW_LAST = RW'(V_TOTAL_ROWS - 1);
  localparam logic [RW-1:0]         ROW_DISP = RW'(V_DISPLAYED);
  localparam logic [RW-1:0]         ROW_VS   = RW'(V_SYNC_ROW);
  localparam logic [3:0]            RA_LAST  = 4'(CHAR_HEIGHT - 1);
  localparam logic [3:0]            ADJ_LAST = 4'(V_ADJUST - 1);
  localparam logic [VW-1:0]         VS_LOAD  = VW'(V_SYNC_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] START    = ADDR_WIDTH'(START_ADDR);

  typedef enum logic {ST_ACTIVE, ST_ADJUST} state_e;

  // Reset parks the raster on the last scanline so the first enable opens a frame.
  localparam state_e     ST_RESET = (V_ADJUST > 0) ? ST_ADJUST : ST_ACTIVE;
  localparam logic [3:0] RA_RESET = (V_ADJUST > 0) ? ADJ_LAST : RA_LAST;

  state_e                state_q, state_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [3:0]            ra_cnt_q, ra_cnt_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] row_start_q, row_start_d;
  logic                  mode_q, mode_d;
  logic [VW-1:0]         vs_cnt_q, vs_cnt_d;

  logic [ADDR_WIDTH-1:0] ma_q, ma_d;
  logic [3:0]            ra_q;
  logic                  de_q, de_d;
  logic                  hs_q, hs_d;
  logic                  vs_q;
  logic                  frame_q;
  logic                  cursor_q, cursor_d;

  logic                  line_adv, new_frame;
  logic [HW-1:0]         ht_cur, hd_cur, hd_nxt, hsp_nxt, hsw_nxt, h_sel;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    ra_cnt_d    = ra_cnt_q;
    row_d       = row_q;
    row_start_d = row_start_q;
    mode_d      = mode_q;
    vs_cnt_d    = vs_cnt_q;
    line_adv    = 1'b0;
    new_frame   = 1'b0;

    ht_cur = mode_q ? HT_80 : HT_40;
    hd_cur = mode_q ? HD_80 : HD_40;

    if (h_cnt_q == ht_cur - HW'(1)) begin
      h_cnt_d  = '0;
      line_adv = 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end

    if (line_adv) begin
      case (state_q)
        ST_ACTIVE: begin
          if (ra_cnt_q == RA_LAST) begin
            ra_cnt_d    = '0;
            row_start_d = row_start_q + ADDR_WIDTH'(hd_cur);
            if (row_q == ROW_LAST) begin
              if (V_ADJUST == 0) new_frame = 1'b1;
              else               state_d   = ST_ADJUST;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            ra_cnt_d = ra_cnt_q + 4'd1;
          end
        end
        ST_ADJUST: begin
          if (ra_cnt_q == ADJ_LAST) new_frame = 1'b1;
          else                      ra_cnt_d  = ra_cnt_q + 4'd1;
        end
        default: state_d = ST_ACTIVE;
      endcase
    end

    if (new_frame) begin
      state_d     = ST_ACTIVE;
      row_d       = '0;
      ra_cnt_d    = '0;
      row_start_d = START;
      mode_d      = col80_i;
    end

    // v_sync length is counted in scanlines so it can run across row and adjust boundaries.
    if (line_adv && state_d == ST_ACTIVE && row_d == ROW_VS && ra_cnt_d == '0)
      vs_cnt_d = VS_LOAD;
    else if (new_frame)
      vs_cnt_d = '0;
    else if (line_adv && vs_cnt_q != '0)
      vs_cnt_d = vs_cnt_q - VW'(1);

    hd_nxt  = mode_d ? HD_80  : HD_40;
    hsp_nxt = mode_d ? HSP_80 : HSP_40;
    hsw_nxt = mode_d ? HSW_80 : HSW_40;
    h_sel   = (h_cnt_d < hd_nxt) ? h_cnt_d : hd_nxt - HW'(1);
    ma_d    = row_start_d + ADDR_WIDTH'(h_sel);
    de_d    = (state_d == ST_ACTIVE) && (row_d < ROW_DISP) && (h_cnt_d < hd_nxt);
    hs_d    = (h_cnt_d >= hsp_nxt) && (h_cnt_d < hsp_nxt + hsw_nxt);
  end

`ifdef VIDEO_RASTER_CURSOR_EN
  localparam int         BW        = $clog2(BLINK_FRAMES + 1);
  localparam logic [3:0] CUR_START = 4'(CURSOR_START);
  localparam logic [3:0] CUR_END   = 4'(CURSOR_END);

  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (new_frame) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = BW'(1);
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    cursor_d = de_d && (ma_d == cursor_addr_i) && (ra_cnt_d >= CUR_START) &&
               (ra_cnt_d <= CUR_END) && blink_d;
  end

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (cclk_en_i) begin
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end
`else
  logic unused_cursor_addr;
  assign unused_cursor_addr = ^cursor_addr_i;
  assign cursor_d           = 1'b0;
`endif

  always_ff @(posedge clk16_i or posedge reset_i) begin
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= ST_RESET;
      h_cnt_q     <= HT_40 - HW'(1);
      ra_cnt_q    <= RA_RESET;
      row_q       <= ROW_LAST;
      row_start_q <= START;
      mode_q      <= 1'b0;
      vs_cnt_q    <= '0;
      ma_q        <= START;
      ra_q        <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      frame_q     <= 1'b0;
      cursor_q    <= 1'b0;
    end else begin
      frame_q <= cclk_en_i & new_frame;
      if (cclk_en_i) begin
        state_q     <= state_d;
        h_cnt_q     <= h_cnt_d;
        ra_cnt_q    <= ra_cnt_d;
        row_q       <= row_d;
        row_start_q <= row_start_d;
        mode_q      <= mode_d;
        vs_cnt_q    <= vs_cnt_d;
        ma_q        <= ma_d;
        ra_q        <= ra_cnt_d;
        de_q        <= de_d;
        hs_q        <= hs_d;
        vs_q        <= (vs_cnt_d != '0);
        cursor_q    <= cursor_d;
      end
    end
  end

  assign ma_o     = ma_q;
  assign ra_o     = ra_q;
  assign de_o     = de_q;
  assign h_sync_o = hs_q;
  assign v_sync_o = vs_q;
  assign frame_o  = frame_q;
  assign cursor_o = cursor_q;

endmodule

// File: tb/tb_video_raster_gen.sv
// Scoreboard bench for video_raster_gen: small config, default config and a cursor config.
// A line-index reference model predicts every enabled cell.
module tb_video_raster_gen;

  typedef struct packed {
    logic [10:0] ma;
    logic [3:0]  ra;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fr;
    logic        cur;
  } out_t;

  typedef struct {
    int ht; int hd; int hsp; int hsw; int ch;
    int vt; int vd; int vsr; int vsw; int va; int start;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, en, col80;
  logic [10:0] cur_addr [3];
  logic [10:0] ma [3];
  logic [3:0]  ra [3];
  logic [2:0]  de, hs, vs, fr, cur;

  cfg_t cfg [3];
  int   mh [3], mline [3], mm [3], mframe [3];
  int   n_fr [3], n_vs [3], n_cur [3];
  out_t exp_q [$];
  int   n_checks = 0;
  int   n_fails  = 0;

  video_raster_gen #(
    .ADDR_WIDTH(11), .START_ADDR('h7FE), .H_TOTAL(8), .H_DISPLAYED(4), .H_SYNC_POS(5),
    .H_SYNC_WIDTH(2), .CHAR_HEIGHT(2), .V_TOTAL_ROWS(4), .V_DISPLAYED(3), .V_SYNC_ROW(3),
    .V_SYNC_WIDTH(1), .V_ADJUST(1)
  ) u_small (
    .clk16_i(clk), .reset_i(rst[0]), .cclk_en_i(en[0]), .col80_i(col80[0]),
    .cursor_addr_i(cur_addr[0]), .ma_o(ma[0]), .ra_o(ra[0]), .de_o(de[0]),
    .h_sync_o(hs[0]), .v_sync_o(vs[0]), .frame_o(fr[0]), .cursor_o(cur[0])
  );

  video_raster_gen u_def (
    .clk16_i(clk), .reset_i(rst[1]), .cclk_en_i(en[1]), .col80_i(col80[1]),
    .cursor_addr_i(cur_addr[1]), .ma_o(ma[1]), .ra_o(ra[1]), .de_o(de[1]),
    .h_sync_o(hs[1]), .v_sync_o(vs[1]), .frame_o(fr[1]), .cursor_o(cur[1])
  );

  video_raster_gen #(
    .ADDR_WIDTH(11), .START_ADDR(0), .H_TOTAL(42), .H_DISPLAYED(40), .H_SYNC_POS(40),
    .H_SYNC_WIDTH(1), .CHAR_HEIGHT(8), .V_TOTAL_ROWS(3), .V_DISPLAYED(2), .V_SYNC_ROW(2),
    .V_SYNC_WIDTH(2), .V_ADJUST(0)
  ) u_cur (
    .clk16_i(clk), .reset_i(rst[2]), .cclk_en_i(en[2]), .col80_i(col80[2]),
    .cursor_addr_i(cur_addr[2]), .ma_o(ma[2]), .ra_o(ra[2]), .de_o(de[2]),
    .h_sync_o(hs[2]), .v_sync_o(vs[2]), .frame_o(fr[2]), .cursor_o(cur[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic out_t observe(input int s);
    return {ma[s], ra[s], de[s], hs[s], vs[s], fr[s], cur[s]};
  endfunction

  function automatic int total_lines(input int s);
    return cfg[s].vt * cfg[s].ch + cfg[s].va;
  endfunction

  function automatic void model_reset(input int s);
    mh[s]     = cfg[s].ht - 1;
    mline[s]  = total_lines(s) - 1;
    mm[s]     = 0;
    mframe[s] = 0;
  endfunction

  function automatic void model_step(input int s);
    if (mh[s] == (cfg[s].ht << mm[s]) - 1) begin
      mh[s] = 0;
      mline[s]++;
      if (mline[s] == total_lines(s)) begin
        mline[s] = 0;
        mm[s]    = int'(col80[s]);
        mframe[s]++;
      end
    end else begin
      mh[s]++;
    end
  endfunction

  function automatic out_t model_out(input int s);
    cfg_t c;
    out_t o;
    int   hd, hsp, hsw, row, hsel, vs0;
    bit   act;
    c   = cfg[s];
    hd  = c.hd << mm[s];
    hsp = c.hsp << mm[s];
    hsw = c.hsw << mm[s];
    act = mline[s] < c.vt * c.ch;
    if (act) begin
      row  = mline[s] / c.ch;
      o.ra = 4'(mline[s] % c.ch);
    end else begin
      row  = c.vt;
      o.ra = 4'(mline[s] - c.vt * c.ch);
    end
    hsel = (mh[s] < hd) ? mh[s] : hd - 1;
    vs0  = c.vsr * c.ch;
    o.ma  = 11'((c.start + row * hd + hsel) % 2048);
    o.de  = act && row < c.vd && mh[s] < hd;
    o.hs  = mh[s] >= hsp && mh[s] < hsp + hsw;
    o.vs  = mline[s] >= vs0 && mline[s] < vs0 + c.vsw;
    o.fr  = mh[s] == 0 && mline[s] == 0;
`ifdef VIDEO_RASTER_CURSOR_EN
    o.cur = o.de && o.ma == cur_addr[s] && o.ra >= 6 && o.ra <= 7 && ((mframe[s] - 1) / 16) % 2 == 0;
`else
    o.cur = 1'b0;
`endif
    return o;
  endfunction

  function automatic out_t reset_out(input int s);
    out_t r;
    r    = '0;
    r.ma = 11'(cfg[s].start);
    return r;
  endfunction

  task automatic compare(input int s, input out_t e, input string who);
    out_t o;
    o = observe(s);
    check({who, " ma"},     o.ma,  e.ma);
    check({who, " ra"},     o.ra,  e.ra);
    check({who, " de"},     o.de,  e.de);
    check({who, " hsync"},  o.hs,  e.hs);
    check({who, " vsync"},  o.vs,  e.vs);
    check({who, " frame"},  o.fr,  e.fr);
    check({who, " cursor"}, o.cur, e.cur);
    n_fr[s]  += int'(o.fr);
    n_vs[s]  += int'(o.vs);
    n_cur[s] += int'(o.cur);
  endtask

  // Called at a falling edge; drives one enable, then idles gap clocks.
  task automatic pulse(input int s, input int gap, input string who);
    out_t e;
    en[s] = 1'b1;
    model_step(s);
    exp_q.push_back(model_out(s));
    @(posedge clk);
    #1;
    en[s] = 1'b0;
    e = exp_q.pop_front();
    compare(s, e, who);
    if (gap > 0) begin
      @(posedge clk);
      #1;
      if (e.fr) check({who, " frame width"}, fr[s], 1'b0);
      repeat (gap - 1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    cfg[0] = '{8, 4, 5, 2, 2, 4, 3, 3, 1, 1, 'h7FE};
    cfg[1] = '{64, 40, 50, 4, 8, 32, 25, 28, 4, 6, 0};
    cfg[2] = '{42, 40, 40, 1, 8, 3, 2, 2, 2, 0, 0};
    rst = 3'b111;
    en = 3'b000;
    col80 = 3'b000;
    cur_addr[0] = 11'd0;
    cur_addr[1] = 11'd0;
    cur_addr[2] = 11'd41;
    for (int s = 0; s < 3; s++) begin
      n_fr[s] = 0;
      n_vs[s] = 0;
      n_cur[s] = 0;
    end

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      compare(s, reset_out(s), "reset");
      model_reset(s);
    end
    rst = 3'b000;

    // Small config, enable every 4th clock, 40 columns for two full frames.
    repeat (144) pulse(0, 3, "small40");
    check("small frame count", n_fr[0], 2);
    check("small vsync enables", n_vs[0], 16);
    // Switch to 80 columns mid-frame; current frame must finish in 40-column timing.
    repeat (36) pulse(0, 3, "small40");
    col80[0] = 1'b1;
    repeat (36) pulse(0, 3, "small40 tail");
    repeat (288) pulse(0, 3, "small80");
    check("small frame count 80", n_fr[0], 5);

    // Default config: run into v_sync, then reset mid-frame.
    repeat (14340) pulse(1, 0, "default");
    check("default in vsync", vs[1], 1'b1);
    rst[1] = 1'b1;
    #1;
    compare(1, reset_out(1), "mid reset");
    model_reset(1);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (5) pulse(1, 0, "after reset");

    // Cursor config over 17 frames: blink on for frames 1-16, off for frame 17.
    repeat (17 * 1008) pulse(2, 0, "cursor");
`ifdef VIDEO_RASTER_CURSOR_EN
    check("cursor cells", n_cur[2], 32);
`else
    check("cursor cells", n_cur[2], 0);
`endif
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
